regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of the 16x16 register file. Two writeback sources
//  (req0 = ALU, req1 = load unit) compete for the port; the block arbitrates round-robin,

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the arbiter priority type.
// Used by the register file, decode and the writeback arbiter.
package regfile_pkg;

    localparam int DW    = 16;       // register data width
    localparam int AW    = 4;        // register address width
    localparam int NREGS = 1 << AW;  // number of architectural registers

    // Which writeback source wins when both request in the same cycle.
    typedef enum logic [0:0] {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset; no grant is issued while it is high
//   valid : request vector, bit 0 = ALU, bit 1 = load unit
//   grant : one-hot (or zero) grant vector, combinational from valid
// After any grant, priority moves to the requester that was not granted, so two
// continuously requesting sources alternate.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    prio_e prio_q;
    prio_e prio_d;

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        // Requests seen during reset are dropped rather than granted.
        if (!rst) begin
            if (valid == 2'b11) begin
                grant = (prio_q == PRIO_REQ0) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
        if (grant[0]) begin
            prio_d = PRIO_REQ1;
        end else if (grant[1]) begin
            prio_d = PRIO_REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_REQ0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter and busy scoreboard.
// Owns the single regfile write port; ALU (req0) and load unit (req1) compete
// round-robin. The winner is registered onto rf_we/rf_waddr/rf_din one cycle
// after the grant. A per-register busy bit is set when decode issues a writer
// and cleared on the edge that performs its regfile write.
//   clk, rst                      : clock, synchronous active-high reset
//   req0_valid/addr/data, ready   : ALU writeback handshake
//   req1_valid/addr/data, ready   : load-unit writeback handshake
//   issue_valid/addr, issue_ready : decode destination reservation
//   busy                          : outstanding-producer bit per register
//   rf_we, rf_waddr, rf_din       : registered regfile write port
module regfile_wb_arbiter #(
    parameter int DW = regfile_pkg::DW,
    parameter int AW = regfile_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DW-1:0]     req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DW-1:0]     req1_data,
    output logic              req1_ready,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_ready,
    output logic [2**AW-1:0]  busy,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_din
);

    localparam int NREGS = 2 ** AW;

    logic [1:0]       grant;
    logic             rf_we_q,    rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_din_q,   rf_din_d;
    logic [NREGS-1:0] busy_q,     busy_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        rf_we_d    = |grant;
        rf_waddr_d = rf_waddr_q;
        rf_din_d   = rf_din_q;
        if (grant[0]) begin
            rf_waddr_d = req0_addr;
            rf_din_d   = req0_data;
        end else if (grant[1]) begin
            rf_waddr_d = req1_addr;
            rf_din_d   = req1_data;
        end

        // A register whose write lands on this edge can be re-reserved now.
        issue_ready = ~busy_q[issue_addr] | (rf_we_q & (rf_waddr_q == issue_addr));

        // Clear first, then set, so a same-edge reservation keeps the bit high.
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_din_q   <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_din_q   <= rf_din_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_din   = rf_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, issue_valid;
    logic [3:0]  req0_addr, req1_addr, issue_addr;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, issue_ready;
    logic [15:0] busy;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_din;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    // Reference model state: which registers have an outstanding producer,
    // which write is currently on the port, and who was granted last.
    logic [15:0] m_busy  = '0;
    logic        m_we    = 1'b0;
    logic [3:0]  m_waddr = '0;
    logic        m_last1 = 1'b1;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .busy        (busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_din      (rf_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port monitor: every rf_we pulse must match the oldest expected write,
    // in the cycle right after its grant.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                         rf_waddr, rf_din, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", {28'd0, rf_waddr}, {28'd0, e.addr});
                chk("wr_data", {16'd0, rf_din}, {16'd0, e.data});
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_write: got rf_we=%b, expected write addr %0h data %0h (cycle %0d)",
                     rf_we, e.addr, e.data, cyc);
        end
    end

    // One clock cycle: compare combinational outputs against the model, queue the
    // expected write for any grant, advance the model, cross the edge.
    task automatic step(output logic [1:0] dg, output logic [1:0] mg);
        logic [1:0] v;
        logic       iexp;
        #2;
        v  = {req1_valid, req0_valid};
        mg = 2'b00;
        if (!rst) begin
            if (v == 2'b11) mg = m_last1 ? 2'b01 : 2'b10;
            else            mg = v;
        end
        dg = {req1_ready, req0_ready};
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, mg[0]});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, mg[1]});
        chk("busy", {16'd0, busy}, {16'd0, m_busy});
        iexp = !m_busy[issue_addr] || (m_we && m_waddr == issue_addr);
        if (!rst) chk("issue_ready", {31'd0, issue_ready}, {31'd0, iexp});
        if (mg[0]) exp_q.push_back('{req0_addr, req0_data, cyc + 1});
        if (mg[1]) exp_q.push_back('{req1_addr, req1_data, cyc + 1});
        if (rst) begin
            m_busy  = '0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_last1 = 1'b1;
        end else begin
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (issue_valid && iexp) m_busy[issue_addr] = 1'b1;
            m_we = (mg != 2'b00);
            if (mg[0]) begin
                m_waddr = req0_addr;
                m_last1 = 1'b0;
            end else if (mg[1]) begin
                m_waddr = req1_addr;
                m_last1 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] dg, mg;
        rst = 1'b1;
        idle();
        req0_addr = '0; req0_data = '0;
        req1_addr = '0; req1_data = '0;
        issue_addr = '0;
        @(posedge clk);
        #1;

        // Reset with a request held: nothing granted, nothing written afterwards.
        req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 16'h1234;
        step(dg, mg);
        step(dg, mg);
        rst = 1'b0;
        req0_valid = 1'b0;
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_waddr", {28'd0, rf_waddr}, 32'd0);
        chk("rst_rf_din", {16'd0, rf_din}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'd0);
        step(dg, mg);
        step(dg, mg);

        // Single source.
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h00AB;
        step(dg, mg);
        chk("single_grant", {30'd0, dg}, 32'd1);
        req0_valid = 1'b0;
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_addr", {28'd0, rf_waddr}, 32'd3);
        chk("single_data", {16'd0, rf_din}, 32'h00AB);
        step(dg, mg);
        chk("single_we_off", {31'd0, rf_we}, 32'd0);
        chk("single_hold_addr", {28'd0, rf_waddr}, 32'd3);

        // A lone req1 grant hands priority back to req0 before the contention run.
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h000B;
        step(dg, mg);
        req1_valid = 1'b0;
        step(dg, mg);

        // Contention: both held for 4 cycles, grants alternate starting with req0.
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'h000A;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h000B;
        for (int i = 0; i < 4; i++) begin
            step(dg, mg);
            chk("contend_grant", {30'd0, dg}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle();
        step(dg, mg);

        // Scoreboard set, blocked re-issue, clear by writeback.
        issue_valid = 1'b1; issue_addr = 4'd5;
        step(dg, mg);
        chk("sb_set5", {31'd0, busy[5]}, 32'd1);
        #1;
        chk("sb_reissue_blocked", {31'd0, issue_ready}, 32'd0);
        step(dg, mg);
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h5555;
        step(dg, mg);
        req0_valid = 1'b0;
        chk("sb_still_busy_on_we", {31'd0, busy[5]}, 32'd1);
        step(dg, mg);
        chk("sb_clear5", {31'd0, busy[5]}, 32'd0);

        // Same-edge set and clear of register 7.
        issue_valid = 1'b1; issue_addr = 4'd7;
        step(dg, mg);
        issue_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 16'h7777;
        step(dg, mg);
        req1_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'd7;
        #1;
        chk("same_edge_ready", {31'd0, issue_ready}, 32'd1);
        step(dg, mg);
        issue_valid = 1'b0;
        chk("same_edge_busy7", {31'd0, busy[7]}, 32'd1);

        // Mid-operation reset with busy=00F0 and a write in flight.
        for (int r = 4; r < 7; r++) begin
            issue_valid = 1'b1; issue_addr = 4'(r);
            step(dg, mg);
        end
        issue_valid = 1'b0;
        chk("mid_busy_f0", {16'd0, busy}, 32'h00F0);
        req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h9999;
        step(dg, mg);
        req0_valid = 1'b0;
        rst = 1'b1;
        step(dg, mg);
        rst = 1'b0;
        chk("mid_rst_busy", {16'd0, busy}, 32'd0);
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        req0_valid = 1'b1; req0_addr = 4'd8; req0_data = 16'h0808;
        req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 16'h0909;
        step(dg, mg);
        chk("mid_rst_prio", {30'd0, dg}, 32'd1);
        req0_valid = 1'b0;
        step(dg, mg);
        req1_valid = 1'b0;
        step(dg, mg);

        // Randomized traffic, requests held until granted, occasional reset.
        for (int n = 0; n < 400; n++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_addr  = 4'($urandom_range(0, 15));
                req0_data  = 16'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_addr  = 4'($urandom_range(0, 15));
                req1_data  = 16'($urandom);
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = 4'($urandom_range(0, 15));
            rst         = ($urandom_range(0, 63) == 0);
            step(dg, mg);
            if (mg[0]) req0_valid = 1'b0;
            if (mg[1]) req1_valid = 1'b0;
        end
        rst = 1'b0;
        idle();
        step(dg, mg);
        step(dg, mg);
        step(dg, mg);
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
